// File: rtl/pool_window_collector.sv
// 2x2 pooling-window consumer: signed-max reduction, optional ReLU,
// row-major pooled-map storage and serial readout of the completed map.
module pool_window_collector #(
    parameter int DATA_W   = 16,
    parameter int OUT_ROWS = 2,
    parameter int OUT_COLS = 2,
    parameter int RELU     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] win0,
    input  logic signed [DATA_W-1:0] win1,
    input  logic signed [DATA_W-1:0] win2,
    input  logic signed [DATA_W-1:0] win3,
    input  logic                     win_valid,
    output logic                     win_ready,
    output logic signed [DATA_W-1:0] pool_map [OUT_ROWS*OUT_COLS],
    output logic                     map_done,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     rd_last,
    output logic                     busy,
    output logic                     drop_err
);

    localparam int N  = OUT_ROWS * OUT_COLS;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] NC    = CW'(N);
    localparam logic [CW-1:0] LASTC = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, STREAM} state_t;

    state_t                   state;
    logic [CW-1:0]            acc_cnt;
    logic [CW-1:0]            wr_cnt;
    logic [CW-1:0]            rd_idx;
    logic                     v1;
    logic                     v2;
    logic signed [DATA_W-1:0] m01;
    logic signed [DATA_W-1:0] m23;
    logic signed [DATA_W-1:0] r2;
    logic signed [DATA_W-1:0] r_c;
    logic [CW-1:0]            idx1;
    logic [CW-1:0]            idx2;
    logic                     accept;
    logic                     arm;
    logic                     rd_fire;

    assign accept  = win_valid & win_ready;
    assign arm     = (state == IDLE) & start;
    assign rd_fire = rd_valid & rd_ready;
    assign busy    = (state != IDLE);

    always_comb begin
        r_c = (m01 > m23) ? m01 : m23;
        if (RELU != 0 && r_c[DATA_W-1])
            r_c = '0;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++)
            if (rd_idx == CW'(i))
                rd_data = pool_map[i];
    end

    // Reduction pipeline: once a window is accepted it drains regardless of FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            m01    <= '0;
            m23    <= '0;
            r2     <= '0;
            idx1   <= '0;
            idx2   <= '0;
            wr_cnt <= '0;
            for (int i = 0; i < N; i++)
                pool_map[i] <= '0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            if (accept) begin
                m01  <= (win0 > win1) ? win0 : win1;
                m23  <= (win2 > win3) ? win2 : win3;
                idx1 <= acc_cnt;
            end
            if (v1) begin
                r2   <= r_c;
                idx2 <= idx1;
            end
            if (arm) begin
                wr_cnt <= '0;
                for (int i = 0; i < N; i++)
                    pool_map[i] <= '0;
            end else if (v2) begin
                for (int i = 0; i < N; i++)
                    if (idx2 == CW'(i))
                        pool_map[i] <= r2;
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc_cnt   <= '0;
            rd_idx    <= '0;
            win_ready <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            map_done  <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            map_done <= 1'b0;
            if (arm)
                drop_err <= 1'b0;
            if (win_valid && !win_ready)
                drop_err <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= COLLECT;
                        acc_cnt   <= '0;
                        rd_idx    <= '0;
                        win_ready <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        if (acc_cnt == LASTC) begin
                            win_ready <= 1'b0;
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (!v1 && !v2 && wr_cnt == NC) begin
                        map_done <= 1'b1;
                        rd_valid <= 1'b1;
                        rd_last  <= (rd_idx == LASTC);
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (rd_fire) begin
                        rd_idx <= rd_idx + 1'b1;
                        if (rd_last) begin
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            rd_last <= ((rd_idx + 1'b1) == LASTC);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_window_collector.sv
// Scoreboard bench for pool_window_collector: two instances (RELU=0/1)
// share stimulus; a monitor checks each readout against queued results.
module tb_pool_window_collector;

    typedef struct {
        logic signed [15:0] d;
        logic               l;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic signed [15:0] win0 = '0;
    logic signed [15:0] win1 = '0;
    logic signed [15:0] win2 = '0;
    logic signed [15:0] win3 = '0;
    logic               win_valid = 1'b0;
    logic               rd_ready = 1'b0;

    logic               win_ready0, win_ready1;
    logic signed [15:0] pm0 [4];
    logic signed [15:0] pm1 [4];
    logic               map_done0, map_done1;
    logic signed [15:0] rd_data0, rd_data1;
    logic               rd_valid0, rd_valid1;
    logic               rd_last0, rd_last1;
    logic               busy0, busy1;
    logic               drop_err0, drop_err1;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   hs0 = 0;
    int   hs1 = 0;
    exp_t q0[$];
    exp_t q1[$];

    pool_window_collector #(.DATA_W(16), .OUT_ROWS(2), .OUT_COLS(2), .RELU(0)) dut0 (
        .clk(clk), .reset(reset), .start(start),
        .win0(win0), .win1(win1), .win2(win2), .win3(win3),
        .win_valid(win_valid), .win_ready(win_ready0), .pool_map(pm0),
        .map_done(map_done0), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .rd_ready(rd_ready), .rd_last(rd_last0), .busy(busy0), .drop_err(drop_err0)
    );

    pool_window_collector #(.DATA_W(16), .OUT_ROWS(2), .OUT_COLS(2), .RELU(1)) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .win0(win0), .win1(win1), .win2(win2), .win3(win3),
        .win_valid(win_valid), .win_ready(win_ready1), .pool_map(pm1),
        .map_done(map_done1), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .rd_ready(rd_ready), .rd_last(rd_last1), .busy(busy1), .drop_err(drop_err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle a readout is presented it must match the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_valid0) begin
                if (q0.size() == 0) begin
                    chk("rd_unexpected0", 1, 0);
                end else begin
                    chk("rd_data0", int'(rd_data0), int'(q0[0].d));
                    chk("rd_last0", int'(rd_last0), int'(q0[0].l));
                    if (rd_ready) begin
                        void'(q0.pop_front());
                        hs0++;
                    end
                end
            end
            if (rd_valid1) begin
                if (q1.size() == 0) begin
                    chk("rd_unexpected1", 1, 0);
                end else begin
                    chk("rd_data1", int'(rd_data1), int'(q1[0].d));
                    chk("rd_last1", int'(rd_last1), int'(q1[0].l));
                    if (rd_ready) begin
                        void'(q1.pop_front());
                        hs1++;
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int a, input int b, input int c, input int d);
        int t = 0;
        win0 = a[15:0];
        win1 = b[15:0];
        win2 = c[15:0];
        win3 = d[15:0];
        win_valid = 1'b1;
        @(negedge clk);
        while (!win_ready0 && t < 20) begin
            t++;
            @(negedge clk);
        end
        chk("win_ready_wait", int'(win_ready0), 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        win_valid = 1'b0;
    endtask

    task automatic check_map(input int e0[4], input int e1[4], input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_map0"}, int'(pm0[i]), e0[i]);
            chk({tag, "_map1"}, int'(pm1[i]), e1[i]);
        end
    endtask

    task automatic run(input int w[4][4], input int e0[4], input int e1[4],
                       input int gap, input bit extra5, input string tag);
        int t = 0;
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{d: e0[i][15:0], l: (i == 3)});
            q1.push_back('{d: e1[i][15:0], l: (i == 3)});
        end
        pulse_start();
        chk({tag, "_drop_clr"}, int'(drop_err0), 0);
        chk({tag, "_busy"}, int'(busy0), 1);
        for (int i = 0; i < 4; i++) begin
            send(w[i][0], w[i][1], w[i][2], w[i][3]);
            if (i < 3)
                repeat (gap) begin
                    @(posedge clk); #1;
                end
        end
        if (extra5) begin
            win0 = 16'sd100;
            win1 = 16'sd100;
            win2 = 16'sd100;
            win3 = 16'sd100;
            win_valid = 1'b1;
            @(posedge clk); #1;
            win_valid = 1'b0;
        end
        while (!map_done0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_done_lat"}, cyc - acc_cyc, 3);
        chk({tag, "_done1"}, int'(map_done1), 1);
        check_map(e0, e1, tag);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, int'(map_done0), 0);
    endtask

    task automatic stream(input logic [3:0] pat, input string tag);
        int b0 = hs0;
        int b1 = hs1;
        int c = 0;
        while (busy0 && c < 60) begin
            rd_ready = pat[c % 4];
            @(posedge clk); #1;
            c++;
        end
        rd_ready = 1'b0;
        chk({tag, "_idle"}, int'(busy0), 0);
        chk({tag, "_rd_valid_off"}, int'(rd_valid0), 0);
        chk({tag, "_hs0"}, hs0 - b0, 4);
        chk({tag, "_hs1"}, hs1 - b1, 4);
        chk({tag, "_q0_empty"}, q0.size(), 0);
        chk({tag, "_drop0"}, int'(drop_err0), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_win_ready"}, int'(win_ready0), 0);
        chk({tag, "_rd_valid"}, int'(rd_valid0), 0);
        chk({tag, "_rd_last"}, int'(rd_last0), 0);
        chk({tag, "_map_done"}, int'(map_done0), 0);
        chk({tag, "_busy"}, int'(busy0), 0);
        chk({tag, "_busy1"}, int'(busy1), 0);
        chk({tag, "_drop_err"}, int'(drop_err0), 0);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_pm0"}, int'(pm0[i]), 0);
            chk({tag, "_pm1"}, int'(pm1[i]), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wa[4][4] = '{'{1, 5, 3, 2}, '{-4, -1, -7, -9}, '{8, 8, 0, 0}, '{-2, 6, 6, -3}};
        int ea0[4] = '{5, -1, 8, 6};
        int ea1[4] = '{5, 0, 8, 6};
        int wx[4][4] = '{'{-32768, 32767, -32768, -32768},
                         '{-32768, -32768, -32768, -32768},
                         '{0, 0, 0, 0}, '{-1, -2, -3, -4}};
        int ex0[4] = '{32767, -32768, 0, -1};
        int ex1[4] = '{32767, 0, 0, 0};

        #12;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run(wa, ea0, ea1, 0, 1'b0, "b2b");
        stream(4'b1111, "b2b");

        pulse_start();
        send(wa[0][0], wa[0][1], wa[0][2], wa[0][3]);
        send(wa[1][0], wa[1][1], wa[1][2], wa[1][3]);
        @(posedge clk); #1;
        chk("mid_partial_pm0", int'(pm0[0]), 5);
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run(wa, ea0, ea1, 2, 1'b0, "gap");
        stream(4'b1001, "gap");

        run(wx, ex0, ex1, 0, 1'b0, "ext");
        stream(4'b1111, "ext");

        win_valid = 1'b1;
        @(posedge clk); #1;
        win_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_drop0", int'(drop_err0), 1);
        chk("idle_drop1", int'(drop_err1), 1);
        chk("idle_busy", int'(busy0), 0);
        check_map(ex0, ex1, "idle_keep");

        run(wa, ea0, ea1, 0, 1'b1, "flush");
        chk("flush_drop0", int'(drop_err0), 1);
        pulse_start();
        chk("stream_start_busy", int'(busy0), 1);
        chk("stream_start_drop", int'(drop_err0), 1);
        chk("stream_start_rdv", int'(rd_valid0), 1);
        check_map(ea0, ea1, "stream_keep");
        rd_ready = 1'b1;
        for (int c = 0; c < 20 && busy0; c++) begin
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        chk("flush_idle", int'(busy0), 0);
        chk("flush_q_empty", q0.size() + q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_window_collector.md
Name: pool_window_collector

Overview:
- Consumer end of the 2x2 pooling-window stream. The window controller emits one window (four signed values plus a valid strobe) per step; this block accepts each window with a ready/valid handshake.
- It reduces each window by signed max, with optional ReLU, and writes the result into a row-major pooled-map register array.
- Once the map is complete it signals done and streams the pooled map out serially to the next layer (flatten/dense input).

Parameters:
- DATA_W, 16, width of activations and results (signed)
- OUT_ROWS, 2, pooled map rows
- OUT_COLS, 2, pooled map columns
- RELU, 0, 1 = clamp negative results to 0 before storing

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; clears the map and arms collection (honoured only in IDLE)
- win0..win3  in  DATA_W each  window values TL, TR, BL, BR (signed)
- win_valid  in  1  window present this cycle
- win_ready  out  1  block accepts a window this cycle
- pool_map  out  DATA_W x OUT_ROWS*OUT_COLS  unpacked array of stored results, row-major
- map_done  out  1  one-cycle pulse when the final result has been written
- rd_data  out  DATA_W  serial readout value
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  downstream accepts rd_data
- rd_last  out  1  high with the final readout element
- busy  out  1  high whenever the FSM is not in IDLE
- drop_err  out  1  sticky; set when win_valid=1 and win_ready=0; cleared by reset or an accepted start

Behaviour:
- N = OUT_ROWS*OUT_COLS. Index counters are sized as clog2(N+1).
- Reset (async) values: FSM=IDLE; wr_cnt=0; rd_idx=0; pipeline valids=0; all pool_map entries=0; win_ready=0; rd_valid=0; rd_last=0; map_done=0; busy=0; drop_err=0. Reset mid-operation aborts everything; in-flight windows are discarded.
- FSM states: IDLE, COLLECT, FLUSH, STREAM.
  - IDLE: start -> COLLECT; zero pool_map, wr_cnt, rd_idx; clear drop_err. start outside IDLE is ignored.
  - COLLECT: win_ready = (acc_cnt < N). Accept when win_valid & win_ready; acc_cnt increments. The accept that makes acc_cnt==N moves the FSM to FLUSH on the next edge.
  - FLUSH: win_ready=0. Wait until pipeline valids are both 0 and wr_cnt==N. On that cycle pulse map_done for one cycle and go to STREAM.
  - STREAM: rd_valid=1, rd_data=pool_map[rd_idx], rd_last=(rd_idx==N-1). On rd_valid & rd_ready, rd_idx increments. The handshake with rd_last=1 returns the FSM to IDLE, with rd_valid low the next cycle. rd_data and rd_last are held stable while rd_ready=0.
- Reduction pipeline (2 stages, independent of FSM state once accepted):
  - S1 registers m01=max(win0,win1), m23=max(win2,win3) (signed compare), plus v1 and the tag idx=acc_cnt.
  - S2 computes r=max(m01,m23). If RELU=1 and r<0, r=0. It writes pool_map[idx]<=r and increments wr_cnt.
  - Latency: a window accepted at edge k is visible in pool_map after edge k+2.
  - Full throughput: one window per cycle.
- Results are row-major; the i-th accepted window goes to index i. No saturation is needed because max preserves range.
- pool_map is also continuously readable in parallel; entries are stable from map_done until the next start.
- drop_err is set on any cycle with win_valid=1 and win_ready=0. This includes IDLE, FLUSH, STREAM, and COLLECT after N accepts. The offending window is ignored.

Test Plan:
- Reset mid-COLLECT after 2 of 4 windows -> all outputs at reset values; busy=0; the next start plus 4 windows yields a correct fresh map.
- start, then 4 back-to-back windows {1,5,3,2},{-4,-1,-7,-9},{8,8,0,0},{-2,6,6,-3} (RELU=0) -> pool_map={5,-1,8,6}; map_done exactly 2 cycles after the 4th accept plus FLUSH exit; stream 5,-1,8,6 with rd_last on 6.
- Same windows with RELU=1 -> pool_map={5,0,8,6}.
- Gapped win_valid (1 window every 3 cycles) plus rd_ready toggling 1,0,0,1 -> identical map; each rd_data holds through stalls; exactly N handshakes; return to IDLE.
- Extremes {-32768,32767,-32768,-32768} and {-32768 x4} -> results 32767 and -32768 (signed-compare check).
- win_valid asserted in IDLE, and a 5th window while in FLUSH -> drop_err=1, map unchanged; start clears drop_err; start pulsed during STREAM is ignored.
